dmem_port_arbiter: RTL and testbench

Arbitrates the single-port synchronous data RAM between two requesters: the CPU MEM stage and an external DMA/debug-loader port.
- CPU has default priority. A starvation counter forces one DMA slot after a bounded wait.
- DMA may hold the port for a capped-length burst.
- cpu_stall tells the pipeline to freeze PC and the pipeline registers, in the same way as wpcir, while the CPU is denied.
- Sits between pipe_stage_MEM's RAM-access logic and the data RAM instance.

---
 rtl/dmem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Single-port data RAM arbiter: CPU MEM stage (default priority) vs. DMA/debug loader.
// Defining ARB_STATS_EN adds wrapping grant/stall statistics outputs.
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4,
    parameter int BURST_MAX  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    // CPU side
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_stall,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    // DMA side
    input  logic                  dma_req,
    input  logic                  dma_burst,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_ack,
    output logic                  dma_rvalid,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    // RAM side
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
`ifdef ARB_STATS_EN
    output logic [31:0]           stat_cpu_grants,
    output logic [31:0]           stat_dma_grants,
    output logic [31:0]           stat_stall_cycles,
`endif
    output logic [0:0]            o_dbg_state
);

    // Handshake: a request is served in the cycle its grant is high (cpu_stall low
    // for the CPU, dma_ack high for DMA); read data follows exactly one cycle later
    // qualified by the matching rvalid, writes complete in the grant cycle.

    localparam logic [0:0] S_CPU = 1'b0;
    localparam logic [0:0] S_DMA = 1'b1;

    localparam logic [1:0] RD_NONE = 2'd0;
    localparam logic [1:0] RD_CPU  = 2'd1;
    localparam logic [1:0] RD_DMA  = 2'd2;

    localparam logic [7:0] MAX_WAIT_C  = 8'(MAX_WAIT);
    localparam logic [7:0] BURST_MAX_C = 8'(BURST_MAX);

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_nxt;
    logic [7:0] r_burst_cnt;
    logic [7:0] w_burst_nxt;
    logic [7:0] w_burst_inc;
    logic [1:0] r_rd_owner;
    logic [1:0] w_rd_owner_nxt;
    logic       w_cpu_gnt;
    logic       w_dma_gnt;
    logic       w_dma_starved;
    logic       w_burst_keep;

    assign w_dma_starved = (r_wait_cnt == MAX_WAIT_C);
    assign w_burst_inc   = (r_burst_cnt >= BURST_MAX_C) ? BURST_MAX_C : r_burst_cnt + 8'd1;
    assign w_burst_keep  = dma_req & dma_burst & (~cpu_req | (r_burst_cnt < BURST_MAX_C));

    // Grant decision; everything is forced idle while reset is held.
    always_comb begin
        w_cpu_gnt   = 1'b0;
        w_dma_gnt   = 1'b0;
        w_state_nxt = r_state;
        w_burst_nxt = r_burst_cnt;
        if (!reset) begin
            case (r_state)
                S_CPU: begin
                    if (dma_req && (!cpu_req || w_dma_starved)) begin
                        w_dma_gnt = 1'b1;
                        if (dma_burst) begin
                            w_state_nxt = S_DMA;
                            w_burst_nxt = 8'd1;
                        end
                    end else if (cpu_req) begin
                        w_cpu_gnt = 1'b1;
                    end
                end
                default: begin
                    if (w_burst_keep) begin
                        w_dma_gnt   = 1'b1;
                        w_burst_nxt = w_burst_inc;
                    end else begin
                        w_state_nxt = S_CPU;
                        w_burst_nxt = 8'd0;
                        if (cpu_req) begin
                            w_cpu_gnt = 1'b1;
                        end else if (dma_req) begin
                            w_dma_gnt = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_wait_nxt = 8'd0;
        if (dma_req && !w_dma_gnt) begin
            w_wait_nxt = w_dma_starved ? r_wait_cnt : r_wait_cnt + 8'd1;
        end
    end

    always_comb begin
        w_rd_owner_nxt = RD_NONE;
        if (w_cpu_gnt && !cpu_we) begin
            w_rd_owner_nxt = RD_CPU;
        end else if (w_dma_gnt && !dma_we) begin
            w_rd_owner_nxt = RD_DMA;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_CPU;
            r_wait_cnt  <= 8'd0;
            r_burst_cnt <= 8'd0;
            r_rd_owner  <= RD_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_rd_owner  <= w_rd_owner_nxt;
        end
    end

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (w_cpu_gnt) begin
            ram_we   = cpu_we;
            ram_addr = cpu_addr;
            ram_din  = cpu_wdata;
        end else if (w_dma_gnt) begin
            ram_we   = dma_we;
            ram_addr = dma_addr;
            ram_din  = dma_wdata;
        end
    end

    assign cpu_stall   = cpu_req & ~w_cpu_gnt;
    assign dma_ack     = w_dma_gnt;
    assign cpu_rvalid  = (r_rd_owner == RD_CPU);
    assign dma_rvalid  = (r_rd_owner == RD_DMA);
    assign cpu_rdata   = cpu_rvalid ? ram_dout : '0;
    assign dma_rdata   = dma_rvalid ? ram_dout : '0;
    assign o_dbg_state = r_state;

`ifdef ARB_STATS_EN
    logic [31:0] r_stat_cpu;
    logic [31:0] r_stat_dma;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stat_cpu   <= 32'd0;
            r_stat_dma   <= 32'd0;
            r_stat_stall <= 32'd0;
        end else begin
            if (w_cpu_gnt) r_stat_cpu <= r_stat_cpu + 32'd1;
            if (w_dma_gnt) r_stat_dma <= r_stat_dma + 32'd1;
            if (cpu_stall) r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign stat_cpu_grants   = r_stat_cpu;
    assign stat_dma_grants   = r_stat_dma;
    assign stat_stall_cycles = r_stat_stall;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a randomized
// run against a cycle-level behavioural model with a shadow memory.
module tb_dmem_port_arbiter;

    localparam int AW        = 8;
    localparam int DW        = 32;
    localparam int MAX_WAIT  = 4;
    localparam int BURST_MAX = 8;

    logic          clock;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          dma_req, dma_burst, dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_ack, dma_rvalid;
    logic [DW-1:0] dma_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic [0:0]    dbg_state;
`ifdef ARB_STATS_EN
    logic [31:0]   stat_cpu_grants, stat_dma_grants, stat_stall_cycles;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    logic [DW-1:0] mem    [0:255];
    logic [DW-1:0] shadow [0:255];
    logic [DW:0]   exp_q[$];

    dmem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)
    ) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_burst(dma_burst), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
`ifdef ARB_STATS_EN
        .stat_cpu_grants(stat_cpu_grants), .stat_dma_grants(stat_dma_grants),
        .stat_stall_cycles(stat_stall_cycles),
`endif
        .o_dbg_state(dbg_state)
    );

    // Clock / reset and the synchronous RAM the arbiter drives.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    // Driver: apply one cycle of inputs just after the falling edge.
    task automatic drive(input logic c_req, input logic c_we, input logic [AW-1:0] c_addr,
                         input logic [DW-1:0] c_wdata, input logic d_req, input logic d_burst,
                         input logic d_we, input logic [AW-1:0] d_addr, input logic [DW-1:0] d_wdata);
        @(negedge clock);
        cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wdata;
        dma_req = d_req; dma_burst = d_burst; dma_we = d_we; dma_addr = d_addr; dma_wdata = d_wdata;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h44; cpu_wdata = 32'h1111_2222;
        dma_req = 1'b1; dma_burst = 1'b1; dma_we = 1'b1; dma_addr = 8'h33; dma_wdata = 32'h3333_4444;
        @(negedge clock); #1;
        n_checks++;
        if ({cpu_stall, dma_ack, ram_we, dbg_state} !== 4'b1000) begin
            n_fails++; $display("FAIL reset_ctrl: got %b expected 1000", {cpu_stall, dma_ack, ram_we, dbg_state});
        end
        n_checks++;
        if ({ram_addr, ram_din} !== '0) begin
            n_fails++; $display("FAIL reset_ram: got addr %h din %h expected 0", ram_addr, ram_din);
        end
        n_checks++;
        if ({cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata} !== '0) begin
            n_fails++; $display("FAIL reset_read: got %b %b %h %h expected all 0", cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata);
        end
        cpu_req = 1'b0; #1;
        n_checks++;
        if (cpu_stall !== 1'b0) begin
            n_fails++; $display("FAIL reset_stall_follows_req: got %b expected 0", cpu_stall);
        end
        @(negedge clock);
        reset = 1'b0;
        dma_req = 1'b0; dma_burst = 1'b0; dma_we = 1'b0; cpu_we = 1'b0;
        idle(1);
    endtask

    task automatic test_cpu_read;
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b1, 8'h10, 32'h0000_0055);
        shadow[8'h10] = 32'h0000_0055;
        n_checks++;
        if ({dma_ack, ram_we, ram_addr, ram_din} !== {1'b1, 1'b1, 8'h10, 32'h0000_0055}) begin
            n_fails++; $display("FAIL preload_write: got ack %b we %b addr %h din %h expected 1 1 10 00000055", dma_ack, ram_we, ram_addr, ram_din);
        end
        drive(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        n_checks++;
        if ({cpu_stall, ram_we, ram_addr} !== {1'b0, 1'b0, 8'h10}) begin
            n_fails++; $display("FAIL cpu_read_grant: got stall %b we %b addr %h expected 0 0 10", cpu_stall, ram_we, ram_addr);
        end
        idle(1);
        n_checks++;
        if ({cpu_rvalid, dma_rvalid, cpu_rdata} !== {1'b1, 1'b0, 32'h0000_0055}) begin
            n_fails++; $display("FAIL cpu_read_data: got rv %b drv %b data %h expected 1 0 00000055", cpu_rvalid, dma_rvalid, cpu_rdata);
        end
        idle(1);
    endtask

    task automatic test_starvation;
        logic exp_dma;
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 1'b0, 8'h20, 32'h0);
            exp_dma = (k % (MAX_WAIT + 1) == 0);
            n_checks++;
            if ({dma_ack, cpu_stall, ram_addr} !== {exp_dma, exp_dma, exp_dma ? 8'h20 : 8'h10}) begin
                n_fails++; $display("FAIL starvation_cycle%0d: got ack %b stall %b addr %h expected ack %b stall %b", k, dma_ack, cpu_stall, ram_addr, exp_dma, exp_dma);
            end
        end
        idle(2);
    endtask

    task automatic test_burst_cap;
        int  acks;
        logic exp_ack, exp_stall;
        acks = 0;
        for (int k = 1; k <= 10; k++) begin
            drive(k >= 3, 1'b0, 8'h10, 32'h0, 1'b1, 1'b1, 1'b0, 8'(8'h40 + acks), 32'h0);
            exp_ack   = (k <= BURST_MAX);
            exp_stall = (k >= 3) && (k <= BURST_MAX);
            n_checks++;
            if ({dma_ack, cpu_stall} !== {exp_ack, exp_stall}) begin
                n_fails++; $display("FAIL burst_cycle%0d: got ack %b stall %b expected %b %b", k, dma_ack, cpu_stall, exp_ack, exp_stall);
            end
            if (dma_ack) acks++;
        end
        n_checks++;
        if (acks !== BURST_MAX) begin
            n_fails++; $display("FAIL burst_ack_count: got %0d expected %0d", acks, BURST_MAX);
        end
        idle(2);
    endtask

    task automatic test_coherency;
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b1, 8'h20, 32'hDEAD_BEEF);
        shadow[8'h20] = 32'hDEAD_BEEF;
        n_checks++;
        if ({dma_ack, ram_we, ram_addr, ram_din} !== {1'b1, 1'b1, 8'h20, 32'hDEAD_BEEF}) begin
            n_fails++; $display("FAIL coh_dma_write: got ack %b we %b addr %h din %h expected 1 1 20 deadbeef", dma_ack, ram_we, ram_addr, ram_din);
        end
        drive(1'b1, 1'b0, 8'h20, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        n_checks++;
        if ({cpu_stall, dma_rvalid} !== 2'b00) begin
            n_fails++; $display("FAIL coh_cpu_grant: got stall %b dma_rvalid %b expected 0 0", cpu_stall, dma_rvalid);
        end
        idle(1);
        n_checks++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
            n_fails++; $display("FAIL coh_cpu_data: got rv %b data %h expected 1 deadbeef", cpu_rvalid, cpu_rdata);
        end
        idle(1);
    endtask

    task automatic test_reset_mid_burst;
        for (int k = 1; k <= 3; k++) begin
            drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 8'(8'h50 + k), 32'h0);
            n_checks++;
            if (dma_ack !== 1'b1) begin
                n_fails++; $display("FAIL rstburst_ack%0d: got %b expected 1", k, dma_ack);
            end
        end
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 8'h54, 32'h0);
        n_checks++;
        if ({dma_ack, dma_rvalid, dbg_state} !== 3'b111) begin
            n_fails++; $display("FAIL rstburst_before: got ack %b rv %b state %b expected 1 1 1", dma_ack, dma_rvalid, dbg_state);
        end
        reset = 1'b1; #1;
        n_checks++;
        if ({dma_ack, dma_rvalid, ram_we, ram_addr, dma_rdata, dbg_state} !== '0) begin
            n_fails++; $display("FAIL rstburst_during: got ack %b rv %b we %b addr %h rdata %h state %b expected all 0", dma_ack, dma_rvalid, ram_we, ram_addr, dma_rdata, dbg_state);
        end
        @(negedge clock);
        reset = 1'b0;
        drive(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        n_checks++;
        if ({cpu_stall, ram_addr} !== {1'b0, 8'h10}) begin
            n_fails++; $display("FAIL rstburst_after_grant: got stall %b addr %h expected 0 10", cpu_stall, ram_addr);
        end
        idle(1);
        n_checks++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, 32'h0000_0055}) begin
            n_fails++; $display("FAIL rstburst_after_data: got rv %b data %h expected 1 00000055", cpu_rvalid, cpu_rdata);
        end
        idle(1);
    endtask

    task automatic test_random;
        logic          c_req, c_we, d_req, d_burst, d_we;
        logic [AW-1:0] c_addr, d_addr;
        logic [DW-1:0] c_wdata, d_wdata, exp_crd, exp_drd;
        logic [DW:0]   e;
        logic          exp_crv, exp_drv, cpu_hold, in_burst, exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_din;
        int            burst_len, waited, gnt;
        for (int a = 0; a < 16; a++) begin
            d_wdata = $urandom;
            drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b1, 8'(a), d_wdata);
            shadow[a] = d_wdata;
            n_checks++;
            if (dma_ack !== 1'b1) begin
                n_fails++; $display("FAIL rand_preload%0d: got ack %b expected 1", a, dma_ack);
            end
        end
        cpu_hold = 1'b0; in_burst = 1'b0; burst_len = 0; waited = 0;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        exp_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!cpu_hold) begin
                c_req = ($urandom_range(0, 99) < 60); c_we = 1'($urandom_range(0, 1));
                c_addr = 8'($urandom_range(0, 15)); c_wdata = $urandom;
            end
            d_req = ($urandom_range(0, 99) < 55); d_burst = ($urandom_range(0, 99) < 70);
            d_we = 1'($urandom_range(0, 1)); d_addr = 8'($urandom_range(0, 15)); d_wdata = $urandom;
            // Reference: who owns the port this cycle (0 none, 1 CPU, 2 DMA).
            gnt = 0;
            if (!in_burst) begin
                if (d_req && (!c_req || waited >= MAX_WAIT)) begin
                    gnt = 2;
                    if (d_burst) begin in_burst = 1'b1; burst_len = 1; end
                end else if (c_req) gnt = 1;
            end else if (d_req && d_burst && (!c_req || burst_len < BURST_MAX)) begin
                gnt = 2;
                if (burst_len < BURST_MAX) burst_len++;
            end else begin
                in_burst = 1'b0; burst_len = 0;
                gnt = c_req ? 1 : (d_req ? 2 : 0);
            end
            if (d_req && gnt != 2) waited = (waited < MAX_WAIT) ? waited + 1 : MAX_WAIT;
            else waited = 0;
            drive(c_req, c_we, c_addr, c_wdata, d_req, d_burst, d_we, d_addr, d_wdata);
            exp_we = 1'b0; exp_addr = '0; exp_din = '0;
            if (gnt == 1) begin exp_we = c_we; exp_addr = c_addr; exp_din = c_wdata; end
            if (gnt == 2) begin exp_we = d_we; exp_addr = d_addr; exp_din = d_wdata; end
            n_checks++;
            if ({cpu_stall, dma_ack, ram_we, ram_addr, ram_din} !== {c_req && gnt != 1, gnt == 2, exp_we, exp_addr, exp_din}) begin
                n_fails++; $display("FAIL rand_port cyc %0d: got stall %b ack %b we %b addr %h din %h expected %b %b %b %h %h", cyc, cpu_stall, dma_ack, ram_we, ram_addr, ram_din, c_req && gnt != 1, gnt == 2, exp_we, exp_addr, exp_din);
            end
            exp_crv = 1'b0; exp_drv = 1'b0; exp_crd = '0; exp_drd = '0;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e[DW]) begin exp_drv = 1'b1; exp_drd = e[DW-1:0]; end
                else       begin exp_crv = 1'b1; exp_crd = e[DW-1:0]; end
            end
            n_checks++;
            if ({cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata} !== {exp_crv, exp_drv, exp_crd, exp_drd}) begin
                n_fails++; $display("FAIL rand_read cyc %0d: got rv %b/%b data %h/%h expected %b/%b %h/%h", cyc, cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata, exp_crv, exp_drv, exp_crd, exp_drd);
            end
            if (gnt == 1 && !c_we) exp_q.push_back({1'b0, shadow[c_addr]});
            if (gnt == 2 && !d_we) exp_q.push_back({1'b1, shadow[d_addr]});
            if (gnt == 1 && c_we) shadow[c_addr] = c_wdata;
            if (gnt == 2 && d_we) shadow[d_addr] = d_wdata;
            cpu_hold = c_req && gnt != 1;
        end
        idle(2);
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats;
        @(negedge clock);
        reset = 1'b1;
        cpu_req = 1'b0; dma_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) drive(1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 1'b0, 8'h20, 32'h0);
        @(posedge clock); #1;
        n_checks++;
        if ({stat_cpu_grants, stat_dma_grants, stat_stall_cycles} !== {32'd8, 32'd2, 32'd2}) begin
            n_fails++; $display("FAIL stats: got cpu %0d dma %0d stall %0d expected 8 2 2", stat_cpu_grants, stat_dma_grants, stat_stall_cycles);
        end
        idle(2);
    endtask
`endif

    initial begin
        test_reset();
        test_cpu_read();
        test_starvation();
        test_burst_cap();
        test_coherency();
        test_reset_mid_burst();
        test_random();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
